// File: rtl/corefifo_pkg.sv
// Shared FIFO helpers: pointer width and binary/gray conversions.
// Conversions work on a 32-bit container; callers cast results back to their pointer width.
package corefifo_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic int ptr_w(input int rdepth);
    return rdepth + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/corefifo_rd_ptr_ctrl_if.sv
// Read-side pointer controller bus: FWFT handshake, RAM read port, cross-domain pointers.
// rdcnt exists only when COREFIFO_RDCNT_EN is defined.
interface corefifo_rd_ptr_ctrl_if
  import corefifo_pkg::*;
#(
  parameter int RDEPTH = 10
);

  localparam int PTR_W = ptr_w(RDEPTH);

  logic              fifo_rd_en;
  logic [PTR_W-1:0]  wptr_gray_i;
  logic              fifo_empty;
  logic              fifo_aempty;
  logic [RDEPTH-1:0] fifo_MEMRADDR;
  logic              mem_re;
  logic [PTR_W-1:0]  rptr_gray_o;
`ifdef COREFIFO_RDCNT_EN
  logic [PTR_W-1:0]  rdcnt;
`endif

  modport master (
    output fifo_rd_en,
    output wptr_gray_i,
    input  fifo_empty,
    input  fifo_aempty,
    input  fifo_MEMRADDR,
    input  mem_re,
`ifdef COREFIFO_RDCNT_EN
    input  rdcnt,
`endif
    input  rptr_gray_o
  );

  modport slave (
    input  fifo_rd_en,
    input  wptr_gray_i,
    output fifo_empty,
    output fifo_aempty,
    output fifo_MEMRADDR,
    output mem_re,
`ifdef COREFIFO_RDCNT_EN
    output rdcnt,
`endif
    output rptr_gray_o
  );

endinterface

// File: rtl/corefifo_rd_gray_sync.sv
// Brings the gray-coded write pointer into the read domain (1 or 2 flops) and decodes it to binary.
module corefifo_rd_gray_sync
  import corefifo_pkg::*;
#(
  parameter int W    = 11,
  parameter int SYNC = 1
) (
  input  logic         pos_rclk,
  input  logic         aresetn_rclk,
  input  logic         sresetn_rclk,
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] bin_out
);

  // Same-clock writer needs only a pipeline register; a foreign clock needs a 2-flop synchronizer.
  localparam int NSTAGES = (SYNC != 0) ? 1 : 2;

  logic [NSTAGES-1:0][W-1:0] sync_reg;

  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      sync_reg <= '0;
    end else if (!sresetn_rclk) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= gray_in;
      for (int i = 1; i < NSTAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign bin_out = W'(gray2bin(GRAY_MAX_W'(sync_reg[NSTAGES-1])));

endmodule

// File: rtl/corefifo_rd_ptr_ctrl.sv
// Read pointer, occupancy and empty/almost-empty flags feeding the FWFT stage.
// Define COREFIFO_RDCNT_EN to add the registered occupancy output rdcnt.
module corefifo_rd_ptr_ctrl
  import corefifo_pkg::*;
#(
  parameter int RDEPTH     = 10,
  parameter int AEMPTY_VAL = 4,
  parameter int SYNC       = 1
) (
  input logic                   pos_rclk,
  input logic                   aresetn_rclk,
  input logic                   sresetn_rclk,
  corefifo_rd_ptr_ctrl_if.slave rd_if
);

  localparam int              PTR_W     = ptr_w(RDEPTH);
  localparam logic [PTR_W-1:0] AEMPTY_TH = PTR_W'(AEMPTY_VAL);

  logic [PTR_W-1:0] rptr_bin_reg;
  logic [PTR_W-1:0] rptr_bin_next;
  logic [PTR_W-1:0] rptr_gray_reg;
  logic [PTR_W-1:0] wptr_bin_s;
  logic [PTR_W-1:0] cnt_next;
  logic             empty_reg;
  logic             aempty_reg;
  logic             rd_acc;

  corefifo_rd_gray_sync #(
    .W    (PTR_W),
    .SYNC (SYNC)
  ) u_wptr_sync (
    .pos_rclk     (pos_rclk),
    .aresetn_rclk (aresetn_rclk),
    .sresetn_rclk (sresetn_rclk),
    .gray_in      (rd_if.wptr_gray_i),
    .bin_out      (wptr_bin_s)
  );

  // A cycle with sync reset asserted never reaches the RAM, so gate it here too.
  assign rd_acc        = rd_if.fifo_rd_en & ~empty_reg & sresetn_rclk;
  assign rptr_bin_next = rptr_bin_reg + PTR_W'(rd_acc);
  assign cnt_next      = wptr_bin_s - rptr_bin_next;

  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      rptr_bin_reg  <= '0;
      rptr_gray_reg <= '0;
      empty_reg     <= 1'b1;
      aempty_reg    <= 1'b1;
    end else if (!sresetn_rclk) begin
      rptr_bin_reg  <= '0;
      rptr_gray_reg <= '0;
      empty_reg     <= 1'b1;
      aempty_reg    <= 1'b1;
    end else begin
      rptr_bin_reg  <= rptr_bin_next;
      rptr_gray_reg <= PTR_W'(bin2gray(GRAY_MAX_W'(rptr_bin_next)));
      empty_reg     <= (cnt_next == '0);
      aempty_reg    <= (cnt_next <= AEMPTY_TH);
    end
  end

`ifdef COREFIFO_RDCNT_EN
  logic [PTR_W-1:0] rdcnt_reg;

  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      rdcnt_reg <= '0;
    end else if (!sresetn_rclk) begin
      rdcnt_reg <= '0;
    end else begin
      rdcnt_reg <= cnt_next;
    end
  end

  assign rd_if.rdcnt = rdcnt_reg;
`endif

  assign rd_if.mem_re        = rd_acc;
  assign rd_if.fifo_MEMRADDR = rptr_bin_reg[RDEPTH-1:0];
  assign rd_if.rptr_gray_o   = rptr_gray_reg;
  assign rd_if.fifo_empty    = empty_reg;
  assign rd_if.fifo_aempty   = aempty_reg;

endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
// Directed bench: RDEPTH=3 / AEMPTY_VAL=4 with a 2-flop (dut_a) and a 1-flop (dut_b) pointer sync.
// Driver pushes hand-computed expectations per cycle; a negedge monitor pops and compares.
module tb_corefifo_rd_ptr_ctrl;

  logic pos_rclk;
  logic aresetn_rclk;
  logic sresetn_rclk;

  corefifo_rd_ptr_ctrl_if #(.RDEPTH(3)) if_a ();
  corefifo_rd_ptr_ctrl_if #(.RDEPTH(3)) if_b ();

  corefifo_rd_ptr_ctrl #(.RDEPTH(3), .AEMPTY_VAL(4), .SYNC(0)) dut_a (
    .pos_rclk     (pos_rclk),
    .aresetn_rclk (aresetn_rclk),
    .sresetn_rclk (sresetn_rclk),
    .rd_if        (if_a.slave)
  );

  corefifo_rd_ptr_ctrl #(.RDEPTH(3), .AEMPTY_VAL(4), .SYNC(1)) dut_b (
    .pos_rclk     (pos_rclk),
    .aresetn_rclk (aresetn_rclk),
    .sresetn_rclk (sresetn_rclk),
    .rd_if        (if_b.slave)
  );

  typedef struct {
    int         idx;
    logic       e;
    logic       ae;
    logic [2:0] addr;
    logic       re;
    logic [3:0] rp;
    logic [3:0] cnt;
    logic       be;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_vec   = 0;

  initial begin
    pos_rclk = 1'b0;
    forever #5 pos_rclk = ~pos_rclk;
  end

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec %0d: got %0d, required %0d", name, idx, act, req);
  endtask

  // One vector = one clock cycle: inputs applied just after posedge, outputs checked at negedge.
  task automatic vec(input logic arstn, input logic srstn, input logic rd, input logic [3:0] wb,
                     input logic e, input logic ae, input logic [2:0] addr, input logic re,
                     input logic [3:0] rp, input logic [3:0] cnt, input logic be);
    exp_t x;
    @(posedge pos_rclk);
    #1;
    aresetn_rclk     = arstn;
    sresetn_rclk     = srstn;
    if_a.fifo_rd_en  = rd;
    if_a.wptr_gray_i = gray4(wb);
    if_b.wptr_gray_i = gray4(wb);
    x.idx = n_vec; x.e = e; x.ae = ae; x.addr = addr; x.re = re;
    x.rp = rp; x.cnt = cnt; x.be = be;
    exp_q.push_back(x);
    n_vec++;
  endtask

  always @(negedge pos_rclk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      $display("vec %0d: rd_en=%0b mem_re=%0b addr=%0d empty=%0b aempty=%0b rptr_gray=%h b_empty=%0b",
               x.idx, if_a.fifo_rd_en, if_a.mem_re, if_a.fifo_MEMRADDR, if_a.fifo_empty,
               if_a.fifo_aempty, if_a.rptr_gray_o, if_b.fifo_empty);
      chk("empty",   x.idx, 8'(if_a.fifo_empty),    8'(x.e));
      chk("aempty",  x.idx, 8'(if_a.fifo_aempty),   8'(x.ae));
      chk("memraddr",x.idx, 8'(if_a.fifo_MEMRADDR), 8'(x.addr));
      chk("mem_re",  x.idx, 8'(if_a.mem_re),        8'(x.re));
      chk("rptr_gray",x.idx, 8'(if_a.rptr_gray_o),  8'(gray4(x.rp)));
      chk("b_empty", x.idx, 8'(if_b.fifo_empty),    8'(x.be));
`ifdef COREFIFO_RDCNT_EN
      chk("rdcnt",   x.idx, 8'(if_a.rdcnt),         8'(x.cnt));
`endif
    end
  end

  initial begin
    aresetn_rclk     = 1'b0;
    sresetn_rclk     = 1'b1;
    if_a.fifo_rd_en  = 1'b1;
    if_a.wptr_gray_i = '0;
    if_b.fifo_rd_en  = 1'b0;
    if_b.wptr_gray_i = '0;

    //  arst srst rd  w    e  ae addr re rp  cnt be
    vec(0, 1, 1, 0,   1, 1, 0, 0, 0,  0, 1);   // async reset, read request ignored
    // wptr 0->1: empty falls 3 edges later (2 for the 1-flop sync)
    vec(1, 1, 0, 1,   1, 1, 0, 0, 0,  0, 1);
    vec(1, 1, 0, 1,   1, 1, 0, 0, 0,  0, 1);
    vec(1, 1, 0, 1,   1, 1, 0, 0, 0,  0, 0);
    vec(1, 1, 1, 1,   0, 1, 0, 1, 0,  1, 0);   // last word read
    vec(1, 1, 1, 1,   1, 1, 1, 0, 1,  0, 0);   // read while empty ignored
    vec(1, 1, 0, 1,   1, 1, 1, 0, 1,  0, 0);
    // six words, continuous read, almost-empty threshold
    vec(1, 1, 0, 7,   1, 1, 1, 0, 1,  0, 0);
    vec(1, 1, 0, 7,   1, 1, 1, 0, 1,  0, 0);
    vec(1, 1, 0, 7,   1, 1, 1, 0, 1,  0, 0);
    vec(1, 1, 1, 7,   0, 0, 1, 1, 1,  6, 0);
    vec(1, 1, 1, 7,   0, 0, 2, 1, 2,  5, 0);
    vec(1, 1, 1, 7,   0, 1, 3, 1, 3,  4, 0);
    vec(1, 1, 1, 7,   0, 1, 4, 1, 4,  3, 0);
    vec(1, 1, 1, 7,   0, 1, 5, 1, 5,  2, 0);
    vec(1, 1, 1, 7,   0, 1, 6, 1, 6,  1, 0);
    vec(1, 1, 1, 7,   1, 1, 7, 0, 7,  0, 0);
    // full depth (8 words), read all, address wraps 7->0
    vec(1, 1, 0, 15,  1, 1, 7, 0, 7,  0, 0);
    vec(1, 1, 0, 15,  1, 1, 7, 0, 7,  0, 0);
    vec(1, 1, 0, 15,  1, 1, 7, 0, 7,  0, 0);
    vec(1, 1, 1, 15,  0, 0, 7, 1, 7,  8, 0);
    vec(1, 1, 1, 15,  0, 0, 0, 1, 8,  7, 0);
    vec(1, 1, 1, 15,  0, 0, 1, 1, 9,  6, 0);
    vec(1, 1, 1, 15,  0, 0, 2, 1, 10, 5, 0);
    vec(1, 1, 1, 15,  0, 1, 3, 1, 11, 4, 0);
    vec(1, 1, 1, 15,  0, 1, 4, 1, 12, 3, 0);
    vec(1, 1, 1, 15,  0, 1, 5, 1, 13, 2, 0);
    vec(1, 1, 1, 15,  0, 1, 6, 1, 14, 1, 0);
    vec(1, 1, 1, 15,  1, 1, 7, 0, 15, 0, 0);
    // pointer wrap 15->0 with writes arriving while reading
    vec(1, 1, 0, 0,   1, 1, 7, 0, 15, 0, 0);
    vec(1, 1, 0, 1,   1, 1, 7, 0, 15, 0, 0);
    vec(1, 1, 0, 2,   1, 1, 7, 0, 15, 0, 1);
    vec(1, 1, 1, 3,   0, 1, 7, 1, 15, 1, 0);
    vec(1, 1, 1, 4,   0, 1, 0, 1, 0,  1, 0);
    vec(1, 1, 1, 4,   0, 1, 1, 1, 1,  1, 0);
    vec(1, 1, 1, 4,   0, 1, 2, 1, 2,  1, 0);
    vec(1, 1, 1, 4,   0, 1, 3, 1, 3,  1, 0);
    vec(1, 1, 1, 4,   1, 1, 4, 0, 4,  0, 0);
    // sync reset pulse mid-stream
    vec(1, 1, 0, 8,   1, 1, 4, 0, 4,  0, 0);
    vec(1, 1, 0, 8,   1, 1, 4, 0, 4,  0, 0);
    vec(1, 1, 0, 8,   1, 1, 4, 0, 4,  0, 0);
    vec(1, 1, 1, 8,   0, 1, 4, 1, 4,  4, 0);
    vec(1, 0, 1, 8,   0, 1, 5, 0, 5,  3, 0);
    vec(1, 1, 1, 8,   1, 1, 0, 0, 0,  0, 1);
    vec(1, 1, 0, 8,   1, 1, 0, 0, 0,  0, 1);
    vec(1, 1, 0, 8,   1, 1, 0, 0, 0,  0, 0);
    vec(1, 1, 0, 8,   0, 0, 0, 0, 0,  8, 0);
    vec(1, 1, 0, 8,   0, 0, 0, 0, 0,  8, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge pos_rclk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
